frame_buffer_scheduler: RTL and testbench
=========================================

FRAME_BUFFER_SCHEDULER -- requirements
Module: frame_buffer_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_BUF, 3, number of frame buffers, legal range 2..4.
- ADDR_W, 32, width of the Avalon byte address.
- BUF_BASE, 32'h0000_0000, byte address of buffer 0.
- BUF_STRIDE, 32'h0010_0000, byte distance between consecutive buffers.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous active-high reset.
- vsync  in  1  one-cycle pulse at frame start, from the video output path.
- pause  in  1  when 1, vsync swaps are suppressed.
- dec_req  in  1  level; decoder wants a buffer to write.
- dec_done  in  1  one-cycle pulse; granted buffer fully written.
- dec_grant  out  1  level; dec_addr is valid and owned by the decoder.
- dec_addr  out  ADDR_W  base address of the decoder's write buffer.
- disp_addr  out  ADDR_W  base address for the video DMA.
- disp_update  out  1  one-cycle pulse; DMA reloads disp_addr.
- drop_count  out  16  frames discarded unshown; saturating.
- repeat_count  out  16  vsyncs with no new frame while not paused; saturating.

Function
REQ-004 Each buffer SHALL hold exactly one state: FREE, WRITING, READY or DISPLAYING.
REQ-005 At most one buffer SHALL be WRITING, at most one READY, and exactly one DISPLAYING at all times.
REQ-006 Buffer i base address SHALL be BUF_BASE + i*BUF_STRIDE, truncated to ADDR_W bits.
REQ-007 When dec_req=1, dec_grant=0 and at least one FREE buffer exists, the lowest-index FREE buffer SHALL become WRITING.
REQ-008 In the case of REQ-007, dec_grant SHALL assert and dec_addr SHALL update on the next cycle (latency 1).
REQ-009 When dec_req=1 and no FREE buffer exists, grant SHALL wait; the scheduler SHALL issue no grant until a buffer becomes FREE.
REQ-010 dec_addr SHALL stay stable while dec_grant=1.
REQ-011 dec_done SHALL be ignored when dec_grant=0.
REQ-012 On dec_done with dec_grant=1, the WRITING buffer SHALL become READY, and dec_grant SHALL deassert on the next cycle.
REQ-013 If a READY buffer already existed at dec_done and is not consumed by a same-cycle vsync, that buffer SHALL become FREE and drop_count SHALL increment.
REQ-014 On vsync with pause=0 and a READY buffer present (evaluated on pre-cycle state), the following SHALL happen:
- DISPLAYING becomes FREE.
- READY becomes DISPLAYING.
- disp_addr updates on the next cycle.
- disp_update pulses for one cycle, coincident with that disp_addr update.
REQ-015 On vsync with pause=0 and no READY buffer, state SHALL be unchanged and repeat_count SHALL increment.
REQ-016 On vsync with pause=1, no state SHALL change, no counter SHALL increment, and disp_update SHALL NOT pulse.
REQ-017 When vsync and dec_done coincide, vsync SHALL act first on the old READY buffer; the just-finished buffer SHALL then become READY, with no drop counted.
REQ-018 A buffer freed by vsync SHALL be eligible for grant on the following cycle, not the same cycle.
REQ-019 drop_count and repeat_count SHALL saturate at 16'hFFFF.

Reset
REQ-020 On reset the following SHALL hold:
- Buffer 0 is DISPLAYING; all others are FREE.
- disp_addr = BUF_BASE.
- dec_addr = 0.
- dec_grant = 0 and disp_update = 0.
- drop_count = 0 and repeat_count = 0.
REQ-021 Reset asserted mid-write SHALL abandon the WRITING buffer (it returns to FREE) with no drop counted; the decoder must re-request.

Structure
REQ-022 Package fb_sched_pkg SHALL hold the buf_state_t enum (FREE, WRITING, READY, DISPLAYING) and the counter width constant CNT_W=16.
REQ-023 One sub-module, fb_free_finder, SHALL be a combinational lowest-index FREE encoder producing a found flag and an index; all state SHALL live in the top module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then dec_req=1 -> dec_grant=1 next cycle; dec_addr=32'h0010_0000 (buffer 1).
- Grant buffer 1, dec_done, then vsync -> disp_update pulse; disp_addr=32'h0010_0000; buffer 0 FREE.
- Two dec_done completions with no vsync between them -> drop_count=1; the second frame is displayed at the next vsync.
- Three vsyncs with no completed frame -> repeat_count=3; disp_addr unchanged; no disp_update.
- vsync and dec_done in the same cycle, with an old READY buffer present -> old frame displayed; new frame READY; drop_count unchanged.
- NUM_BUF=2, decoder finishes with no vsync -> next dec_req waits until a vsync frees a buffer; grant follows one cycle after that vsync.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// Frame buffer scheduler shared types and constants.
// Buffer ownership states, counter width, saturating increment.
package fb_sched_pkg;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WRITING    = 2'd1,
        READY      = 2'd2,
        DISPLAYING = 2'd3
    } buf_state_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fb_free_finder.sv
// Lowest-index FREE buffer encoder (purely combinational).
// Ports: free_i (one bit per FREE buffer) -> found_o, idx_o.
module fb_free_finder #(
    parameter int NUM_BUF = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_BUF-1:0] free_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan high to low so the lowest set bit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Rotates NUM_BUF frame buffers between a decoder and a video DMA.
// Ports: clk, reset, vsync, pause, dec_req/done -> dec_grant/addr,
// disp_addr, disp_update, drop_count, repeat_count.
module frame_buffer_scheduler
    import fb_sched_pkg::*;
#(
    parameter int                NUM_BUF    = 3,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BUF_BASE   = '0,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(32'h0010_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              pause,
    input  logic              dec_req,
    input  logic              dec_done,
    output logic              dec_grant,
    output logic [ADDR_W-1:0] dec_addr,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_update,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  repeat_count
);

    localparam int IDX_W = $clog2(NUM_BUF);

    buf_state_t        st_q [NUM_BUF];
    buf_state_t        st_d [NUM_BUF];
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic              upd_q, upd_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  rep_q, rep_d;

    logic [NUM_BUF-1:0] free_mask;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    logic             has_ready;
    logic [IDX_W-1:0] ready_idx;
    logic [IDX_W-1:0] disp_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             live_vs;
    logic             swap;
    logic             done;

    function automatic logic [ADDR_W-1:0] buf_addr(
        input logic [IDX_W-1:0] idx
    );
        return BUF_BASE + ADDR_W'(idx) * BUF_STRIDE;
    endfunction

    // Grant eligibility uses registered state only, so a buffer
    // freed by vsync becomes grantable one cycle later.
    always_comb begin
        for (int i = 0; i < NUM_BUF; i++) begin
            free_mask[i] = (st_q[i] == FREE);
        end
    end

    fb_free_finder #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_free_finder (
        .free_i  (free_mask),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    always_comb begin
        st_d        = st_q;
        grant_d     = grant_q;
        dec_addr_d  = dec_addr_q;
        disp_addr_d = disp_addr_q;
        upd_d       = 1'b0;
        drop_d      = drop_q;
        rep_d       = rep_q;
        has_ready   = 1'b0;
        ready_idx   = '0;
        disp_idx    = '0;
        wr_idx      = '0;

        for (int i = 0; i < NUM_BUF; i++) begin
            unique case (st_q[i])
                READY: begin
                    has_ready = 1'b1;
                    ready_idx = IDX_W'(i);
                end
                DISPLAYING: disp_idx = IDX_W'(i);
                WRITING:    wr_idx   = IDX_W'(i);
                default: ;
            endcase
        end

        live_vs = vsync && !pause;
        swap    = live_vs && has_ready;
        done    = dec_done && grant_q;

        if (swap) begin
            st_d[disp_idx]  = FREE;
            st_d[ready_idx] = DISPLAYING;
            disp_addr_d     = buf_addr(ready_idx);
            upd_d           = 1'b1;
        end else if (live_vs) begin
            rep_d = sat_inc(rep_q);
        end

        // vsync has already taken the old READY frame if it fired;
        // otherwise the old READY frame is overwritten and dropped.
        if (done) begin
            if (has_ready && !swap) begin
                st_d[ready_idx] = FREE;
                drop_d          = sat_inc(drop_q);
            end
            st_d[wr_idx] = READY;
            grant_d      = 1'b0;
        end

        if (dec_req && !grant_q && free_found) begin
            st_d[free_idx] = WRITING;
            grant_d        = 1'b1;
            dec_addr_d     = buf_addr(free_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                st_q[i] <= (i == 0) ? DISPLAYING : FREE;
            end
            grant_q     <= 1'b0;
            dec_addr_q  <= '0;
            disp_addr_q <= BUF_BASE;
            upd_q       <= 1'b0;
            drop_q      <= '0;
            rep_q       <= '0;
        end else begin
            st_q        <= st_d;
            grant_q     <= grant_d;
            dec_addr_q  <= dec_addr_d;
            disp_addr_q <= disp_addr_d;
            upd_q       <= upd_d;
            drop_q      <= drop_d;
            rep_q       <= rep_d;
        end
    end

    assign dec_grant    = grant_q;
    assign dec_addr     = dec_addr_q;
    assign disp_addr    = disp_addr_q;
    assign disp_update  = upd_q;
    assign drop_count   = drop_q;
    assign repeat_count = rep_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed vector bench for frame_buffer_scheduler.
// Drives a 3-buffer and a 2-buffer instance from a shared clock.
module tb_frame_buffer_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst3, vs3, ps3, rq3, dn3;
    logic        g3, up3;
    logic [31:0] da3, pa3;
    logic [15:0] dr3, rp3;

    logic        rst2, vs2, ps2, rq2, dn2;
    logic        g2, up2;
    logic [31:0] da2, pa2;
    logic [15:0] dr2, rp2;

    frame_buffer_scheduler #(.NUM_BUF(3)) dut3 (
        .clk          (clk),
        .reset        (rst3),
        .vsync        (vs3),
        .pause        (ps3),
        .dec_req      (rq3),
        .dec_done     (dn3),
        .dec_grant    (g3),
        .dec_addr     (da3),
        .disp_addr    (pa3),
        .disp_update  (up3),
        .drop_count   (dr3),
        .repeat_count (rp3)
    );

    frame_buffer_scheduler #(.NUM_BUF(2)) dut2 (
        .clk          (clk),
        .reset        (rst2),
        .vsync        (vs2),
        .pause        (ps2),
        .dec_req      (rq2),
        .dec_done     (dn2),
        .dec_grant    (g2),
        .dec_addr     (da2),
        .disp_addr    (pa2),
        .disp_update  (up2),
        .drop_count   (dr2),
        .repeat_count (rp2)
    );

    typedef struct {
        logic        v, p, rq, dn;
        logic        g;
        logic [31:0] da, pa;
        logic        up;
        logic [15:0] dr, rp;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A0 = 32'h0000_0000;
    localparam logic [31:0] A1 = 32'h0010_0000;
    localparam logic [31:0] A2 = 32'h0020_0000;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, p, rq, dn, g,
        input logic [31:0] da, pa,
        input logic up,
        input int dr, rp
    );
        vec_t r;
        r.v  = v;  r.p  = p;
        r.rq = rq; r.dn = dn;
        r.g  = g;  r.da = da;
        r.pa = pa; r.up = up;
        r.dr = 16'(dr);
        r.rp = 16'(rp);
        return r;
    endfunction

    task automatic chk3(input string nm,
                        input logic g,
                        input logic [31:0] da, pa,
                        input logic up,
                        input logic [15:0] dr, rp);
        chk({nm, ".grant"}, 32'(g3), 32'(g));
        chk({nm, ".daddr"}, da3, da);
        chk({nm, ".paddr"}, pa3, pa);
        chk({nm, ".upd"}, 32'(up3), 32'(up));
        chk({nm, ".drop"}, 32'(dr3), 32'(dr));
        chk({nm, ".rep"}, 32'(rp3), 32'(rp));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v p r d  g  daddr paddr u dr rp
        tbl[0]  = mk(0,0,1,0, 1, A1, A0, 0, 0, 0);
        tbl[1]  = mk(0,0,1,0, 1, A1, A0, 0, 0, 0);
        tbl[2]  = mk(0,0,0,1, 0, A1, A0, 0, 0, 0);
        tbl[3]  = mk(1,0,0,0, 0, A1, A1, 1, 0, 0);
        tbl[4]  = mk(0,0,0,0, 0, A1, A1, 0, 0, 0);
        tbl[5]  = mk(0,0,1,0, 1, A0, A1, 0, 0, 0);
        tbl[6]  = mk(0,0,0,1, 0, A0, A1, 0, 0, 0);
        tbl[7]  = mk(0,0,1,0, 1, A2, A1, 0, 0, 0);
        tbl[8]  = mk(0,0,0,1, 0, A2, A1, 0, 1, 0);
        tbl[9]  = mk(1,0,0,0, 0, A2, A2, 1, 1, 0);
        tbl[10] = mk(1,0,0,0, 0, A2, A2, 0, 1, 1);
        tbl[11] = mk(1,0,0,0, 0, A2, A2, 0, 1, 2);
        tbl[12] = mk(1,0,0,0, 0, A2, A2, 0, 1, 3);
        tbl[13] = mk(1,1,0,0, 0, A2, A2, 0, 1, 3);
        tbl[14] = mk(0,0,0,1, 0, A2, A2, 0, 1, 3);
        tbl[15] = mk(0,0,1,0, 1, A0, A2, 0, 1, 3);
        tbl[16] = mk(0,0,0,1, 0, A0, A2, 0, 1, 3);
        tbl[17] = mk(0,0,1,0, 1, A1, A2, 0, 1, 3);
        tbl[18] = mk(1,0,0,1, 0, A1, A0, 1, 1, 3);
        tbl[19] = mk(1,0,0,0, 0, A1, A1, 1, 1, 3);
        tbl[20] = mk(0,0,1,0, 1, A0, A1, 0, 1, 3);
        tbl[21] = mk(0,0,0,1, 0, A0, A1, 0, 1, 3);
        tbl[22] = mk(1,1,0,0, 0, A0, A1, 0, 1, 3);
        tbl[23] = mk(1,0,0,0, 0, A0, A0, 1, 1, 3);

        rst3 = 1; vs3 = 0; ps3 = 0; rq3 = 0; dn3 = 0;
        rst2 = 1; vs2 = 0; ps2 = 0; rq2 = 0; dn2 = 0;
        tick(); tick();
        rst3 = 0; rst2 = 0;
        chk3("rst", 0, A0, A0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            vs3 = tbl[i].v;  ps3 = tbl[i].p;
            rq3 = tbl[i].rq; dn3 = tbl[i].dn;
            tick();
            chk3($sformatf("v%0d", i), tbl[i].g,
                 tbl[i].da, tbl[i].pa, tbl[i].up,
                 tbl[i].dr, tbl[i].rp);
        end
        vs3 = 0; ps3 = 0; rq3 = 0; dn3 = 0;

        // Reset mid-write abandons the buffer, no drop.
        rq3 = 1; tick();
        chk("mw.grant", 32'(g3), 32'd1);
        rq3 = 0; rst3 = 1; tick();
        rst3 = 0;
        chk3("mw.rst", 0, A0, A0, 0, 0, 0);
        rq3 = 1; tick(); rq3 = 0;
        chk("mw.regrant", 32'(g3), 32'd1);
        chk("mw.addr", da3, A1);

        // Two-buffer stall: grant waits for a vsync-freed buffer.
        rq2 = 1; tick();
        chk("n2.g1", 32'(g2), 32'd1);
        chk("n2.a1", da2, A1);
        rq2 = 0; dn2 = 1; tick(); dn2 = 0;
        chk("n2.done", 32'(g2), 32'd0);
        rq2 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("n2.wait%0d", k), 32'(g2), 32'd0);
        end
        vs2 = 1; tick(); vs2 = 0;
        chk("n2.vs.g", 32'(g2), 32'd0);
        chk("n2.vs.upd", 32'(up2), 32'd1);
        chk("n2.vs.pa", pa2, A1);
        tick();
        chk("n2.post.g", 32'(g2), 32'd1);
        chk("n2.post.a", da2, A0);
        chk("n2.post.upd", 32'(up2), 32'd0);
        rq2 = 0;

        // repeat_count saturation on the 3-buffer instance.
        rst3 = 1; rq3 = 0; tick(); rst3 = 0;
        vs3 = 1;
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(rp3), 32'h0000_fffe);
        tick();
        chk("sat.ffff", 32'(rp3), 32'h0000_ffff);
        tick(); tick();
        chk("sat.hold", 32'(rp3), 32'h0000_ffff);
        chk("sat.pa", pa3, A0);
        chk("sat.upd", 32'(up3), 32'd0);
        vs3 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
